udp_packer_rgb24: RTL



---
 rtl/udp_rgb24_pkg.sv | 24 ++
 rtl/udp_packer_rgb24.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/udp_rgb24_pkg.sv
// -----------------------------------------------------------------------------
// udp_rgb24_pkg
// Shared definitions for the UDP RGB24 transmit packer and the receive parser.
//   state_t                 : serializer FSM states (idle, then one per byte lane)
//   BYTE_B/BYTE_G/BYTE_R    : byte-lane index of each channel inside the 24-bit
//                             pixel word {B,G,R}; blue occupies bits [23:16]
//   DEFAULT_PIXELS_PER_PKT  : default pixels per UDP payload (1440 bytes)
// -----------------------------------------------------------------------------
package udp_rgb24_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_B    = 2'd1,
      S_G    = 2'd2,
      S_R    = 2'd3
   } state_t;

   localparam int BYTE_B = 2;
   localparam int BYTE_G = 1;
   localparam int BYTE_R = 0;

   localparam int DEFAULT_PIXELS_PER_PKT = 480;

endpackage

// File: rtl/udp_packer_rgb24.sv
// -----------------------------------------------------------------------------
// udp_packer_rgb24
// Serializes 24-bit pixels into a UDP payload byte stream (B, G, R per pixel)
// and closes a payload every PIXELS_PER_PKT pixels or on a frame-end pixel.
//
// Ports
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_valid / o_ready     : pixel handshake
//   i_channel_B/G/R       : pixel channels
//   i_last                : last pixel of the frame, closes the payload early
//   o_udp_tx_valid/_last/_data, i_udp_tx_ready : byte stream to the UDP core
//   o_pkt_count           : payloads completed (wraps), debug only
//   o_busy                : a pixel is being serialized
// -----------------------------------------------------------------------------
module udp_packer_rgb24
   import udp_rgb24_pkg::*;
#(
   parameter int PIXELS_PER_PKT = DEFAULT_PIXELS_PER_PKT,
   parameter int PKT_CNT_W      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [7:0]           i_channel_B,
   input  logic [7:0]           i_channel_G,
   input  logic [7:0]           i_channel_R,
   input  logic                 i_last,
   output logic                 o_udp_tx_valid,
   output logic                 o_udp_tx_last,
   output logic [7:0]           o_udp_tx_data,
   input  logic                 i_udp_tx_ready,
   output logic [PKT_CNT_W-1:0] o_pkt_count,
   output logic                 o_busy
);

   localparam int                   PIX_CNT_W = $clog2(PIXELS_PER_PKT + 1);
   localparam logic [PIX_CNT_W-1:0] LAST_IDX  = PIX_CNT_W'(PIXELS_PER_PKT - 1);

   state_t                 state_reg, state_next;
   logic [23:0]            pixel_reg, pixel_next;
   logic                   last_flag_reg, last_flag_next;
   logic [PIX_CNT_W-1:0]   pix_cnt_reg, pix_cnt_next;
   logic [PKT_CNT_W-1:0]   pkt_cnt_reg, pkt_cnt_next;

   logic [7:0]             lane_bytes [3];
   logic                   r_done;
   logic                   accept;

   // Byte lanes of the registered pixel; output data never comes from inputs.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign lane_bytes[gi] = pixel_reg[gi*8 +: 8];
      end
   endgenerate

   // The R byte handshake frees the pixel register in the same cycle, so a
   // new pixel can be taken then; this keeps the stream at 3 cycles/pixel.
   assign r_done   = (state_reg == S_R) && i_udp_tx_ready;
   assign o_ready  = (state_reg == S_IDLE) || r_done;
   assign accept   = i_valid && o_ready;

   assign o_busy      = (state_reg != S_IDLE);
   assign o_pkt_count = pkt_cnt_reg;

   always_comb begin
      state_next     = state_reg;
      pixel_next     = pixel_reg;
      last_flag_next = last_flag_reg;
      pix_cnt_next   = pix_cnt_reg;
      pkt_cnt_next   = pkt_cnt_reg;
      o_udp_tx_valid = 1'b0;
      o_udp_tx_last  = 1'b0;
      o_udp_tx_data  = 8'h00;

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = S_B;
            end
         end
         S_B: begin
            o_udp_tx_valid = 1'b1;
            o_udp_tx_data  = lane_bytes[BYTE_B];
            if (i_udp_tx_ready) begin
               state_next = S_G;
            end
         end
         S_G: begin
            o_udp_tx_valid = 1'b1;
            o_udp_tx_data  = lane_bytes[BYTE_G];
            if (i_udp_tx_ready) begin
               state_next = S_R;
            end
         end
         S_R: begin
            o_udp_tx_valid = 1'b1;
            o_udp_tx_data  = lane_bytes[BYTE_R];
            o_udp_tx_last  = last_flag_reg;
            if (i_udp_tx_ready) begin
               state_next = accept ? S_B : S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (r_done) begin
         if (last_flag_reg) begin
            pix_cnt_next = '0;
            pkt_cnt_next = pkt_cnt_reg + PKT_CNT_W'(1);
         end else begin
            pix_cnt_next = pix_cnt_reg + PIX_CNT_W'(1);
         end
      end

      // The last-of-packet decision uses the count after any concurrent R
      // handshake, so a pixel taken alongside a tlast byte starts at index 0.
      if (accept) begin
         pixel_next     = {i_channel_B, i_channel_G, i_channel_R};
         last_flag_next = i_last || (pix_cnt_next == LAST_IDX);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= S_IDLE;
         pixel_reg     <= '0;
         last_flag_reg <= 1'b0;
         pix_cnt_reg   <= '0;
         pkt_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         pixel_reg     <= pixel_next;
         last_flag_reg <= last_flag_next;
         pix_cnt_reg   <= pix_cnt_next;
         pkt_cnt_reg   <= pkt_cnt_next;
      end
   end

endmodule
